screen_unscaling: RTL and testbench

Inverse of the vertex scaling stage: converts one 4-vertex packet of screen-space coordinates (X in units of 1/320 of a normalized unit, Y in units of 1/240) back to signed Q15 normalized coordinates for picking and clipping feedback. Ready/valid handshakes on both sides. X/Y are divided iteratively by a single shared sequential divider. Z passes through unchanged. Sits between the rasteriser's hit-test logic and the geometry stage.

---
 rtl/render_pkg.sv | 28 ++
 rtl/screen_unscaling_if.sv | 45 ++++
 rtl/screen_unscaling_seq_udiv.sv | 58 +++++
 rtl/screen_unscaling.sv | 127 ++++++++++++
 tb/tb_screen_unscaling.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/render_pkg.sv
// Shared widths, constants and FSM states for the screen-space unscaling stage.
package render_pkg;
  localparam int COORD_W  = 21;
  localparam int DIV_W    = 32;
  localparam int NUM_VTX  = 4;
  localparam int NUM_OPND = 2 * NUM_VTX;

  localparam int X_SHIFT = 9;
  localparam int Y_SHIFT = 11;
  localparam logic [DIV_W-1:0] X_DIV = 32'd5;
  localparam logic [DIV_W-1:0] Y_DIV = 32'd15;

  localparam logic signed [COORD_W-1:0] SAT_POS = 21'sh0FFFFF;
  localparam logic signed [COORD_W-1:0] SAT_NEG = 21'sh100000;
  localparam logic [DIV_W-1:0] MAG_POS_MAX = 32'd1048575;
  localparam logic [DIV_W-1:0] MAG_NEG_MAX = 32'd1048576;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  // Reapply the sign to an unsigned quotient and clamp to the Q15 coordinate range.
  function automatic logic signed [COORD_W-1:0] sat_result(input logic neg,
                                                           input logic [DIV_W-1:0] q);
    logic signed [COORD_W-1:0] r;
    if (!neg) r = (q > MAG_POS_MAX) ? SAT_POS : q[COORD_W-1:0];
    else      r = (q > MAG_NEG_MAX) ? SAT_NEG : (~q[COORD_W-1:0] + 1'b1);
    return r;
  endfunction
endpackage

// File: rtl/screen_unscaling_if.sv
// Packet handshake bundle: four scaled vertices in, four normalized vertices out.
interface screen_unscaling_if;
  import render_pkg::*;

  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  logic signed [COORD_W-1:0] vtx1_X_scaled, vtx1_Y_scaled, vtx1_Z_scaled;
  logic signed [COORD_W-1:0] vtx2_X_scaled, vtx2_Y_scaled, vtx2_Z_scaled;
  logic signed [COORD_W-1:0] vtx3_X_scaled, vtx3_Y_scaled, vtx3_Z_scaled;
  logic signed [COORD_W-1:0] vtx4_X_scaled, vtx4_Y_scaled, vtx4_Z_scaled;

  logic signed [COORD_W-1:0] vtx1_X_raw, vtx1_Y_raw, vtx1_Z_raw;
  logic signed [COORD_W-1:0] vtx2_X_raw, vtx2_Y_raw, vtx2_Z_raw;
  logic signed [COORD_W-1:0] vtx3_X_raw, vtx3_Y_raw, vtx3_Z_raw;
  logic signed [COORD_W-1:0] vtx4_X_raw, vtx4_Y_raw, vtx4_Z_raw;

  modport master (
    output in_valid, out_ready,
    output vtx1_X_scaled, vtx1_Y_scaled, vtx1_Z_scaled,
    output vtx2_X_scaled, vtx2_Y_scaled, vtx2_Z_scaled,
    output vtx3_X_scaled, vtx3_Y_scaled, vtx3_Z_scaled,
    output vtx4_X_scaled, vtx4_Y_scaled, vtx4_Z_scaled,
    input  in_ready, out_valid,
    input  vtx1_X_raw, vtx1_Y_raw, vtx1_Z_raw,
    input  vtx2_X_raw, vtx2_Y_raw, vtx2_Z_raw,
    input  vtx3_X_raw, vtx3_Y_raw, vtx3_Z_raw,
    input  vtx4_X_raw, vtx4_Y_raw, vtx4_Z_raw
  );

  modport slave (
    input  in_valid, out_ready,
    input  vtx1_X_scaled, vtx1_Y_scaled, vtx1_Z_scaled,
    input  vtx2_X_scaled, vtx2_Y_scaled, vtx2_Z_scaled,
    input  vtx3_X_scaled, vtx3_Y_scaled, vtx3_Z_scaled,
    input  vtx4_X_scaled, vtx4_Y_scaled, vtx4_Z_scaled,
    output in_ready, out_valid,
    output vtx1_X_raw, vtx1_Y_raw, vtx1_Z_raw,
    output vtx2_X_raw, vtx2_Y_raw, vtx2_Z_raw,
    output vtx3_X_raw, vtx3_Y_raw, vtx3_Z_raw,
    output vtx4_X_raw, vtx4_Y_raw, vtx4_Z_raw
  );
endinterface

// File: rtl/screen_unscaling_seq_udiv.sv
// 32-bit unsigned restoring divider, one quotient bit per cycle, MSB first.
module seq_udiv
  import render_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);
  logic [DIV_W-1:0] rem, quo;
  logic [DIV_W-1:0] rem_in, quo_in, rem_nxt, quo_nxt;
  logic [DIV_W:0]   trial;
  logic [4:0]       cnt;
  logic             busy;

  // The start edge already performs the first step, so 32 edges yield the full quotient.
  always_comb begin
    rem_in = start ? '0 : rem;
    quo_in = start ? dividend : quo;
    trial  = {rem_in, quo_in[DIV_W-1]} - {1'b0, divisor};
    if (trial[DIV_W]) begin
      rem_nxt = {rem_in[DIV_W-2:0], quo_in[DIV_W-1]};
      quo_nxt = {quo_in[DIV_W-2:0], 1'b0};
    end else begin
      rem_nxt = trial[DIV_W-1:0];
      quo_nxt = {quo_in[DIV_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rem  <= rem_nxt;
      quo  <= quo_nxt;
      cnt  <= 5'd1;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign quotient = quo;
endmodule

// File: rtl/screen_unscaling.sv
// Converts a 4-vertex screen-space packet back to signed Q15 coordinates using one shared divider.
module screen_unscaling
  import render_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  screen_unscaling_if.slave  bus
);
  state_t state, state_nxt;

  logic signed [COORD_W-1:0] scaled [NUM_OPND];
  logic signed [COORD_W-1:0] z_in   [NUM_VTX];
  logic signed [COORD_W-1:0] opnd   [NUM_OPND];
  logic signed [COORD_W-1:0] res    [NUM_OPND];
  logic signed [COORD_W-1:0] z_res  [NUM_VTX];

  logic [2:0]         idx;
  logic [4:0]         iter;
  logic               in_ready, out_valid, div_start, div_done;
  logic [COORD_W-1:0] cur, mag;
  logic               neg;
  logic [DIV_W-1:0]   dividend, divisor, quotient;

  assign scaled[0] = bus.vtx1_X_scaled;
  assign scaled[1] = bus.vtx1_Y_scaled;
  assign scaled[2] = bus.vtx2_X_scaled;
  assign scaled[3] = bus.vtx2_Y_scaled;
  assign scaled[4] = bus.vtx3_X_scaled;
  assign scaled[5] = bus.vtx3_Y_scaled;
  assign scaled[6] = bus.vtx4_X_scaled;
  assign scaled[7] = bus.vtx4_Y_scaled;
  assign z_in[0]   = bus.vtx1_Z_scaled;
  assign z_in[1]   = bus.vtx2_Z_scaled;
  assign z_in[2]   = bus.vtx3_Z_scaled;
  assign z_in[3]   = bus.vtx4_Z_scaled;

  // Odd indices are Y operands; the magnitude of -2^20 is exactly 2^20 as an unsigned value.
  always_comb begin
    cur      = opnd[idx];
    neg      = cur[COORD_W-1];
    mag      = neg ? (~cur + 1'b1) : cur;
    dividend = idx[0] ? (DIV_W'(mag) << Y_SHIFT) : (DIV_W'(mag) << X_SHIFT);
    divisor  = idx[0] ? Y_DIV : X_DIV;
  end

  seq_udiv u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        div_start = 1'b1;
        state_nxt = ITER;
      end
      ITER: if (iter == 5'd31) state_nxt = (idx == 3'd7) ? DONE : LOAD;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      iter <= '0;
      for (int i = 0; i < NUM_OPND; i++) begin
        opnd[i] <= '0;
        res[i]  <= '0;
      end
      for (int i = 0; i < NUM_VTX; i++) z_res[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid && in_ready) begin
          idx <= '0;
          for (int i = 0; i < NUM_OPND; i++) opnd[i] <= scaled[i];
          for (int i = 0; i < NUM_VTX; i++) z_res[i] <= z_in[i];
        end
        LOAD: iter <= '0;
        ITER: begin
          iter <= iter + 5'd1;
          if (iter == 5'd31) begin
            if (div_done) res[idx] <= sat_result(neg, quotient);
            if (idx != 3'd7) idx <= idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.vtx1_X_raw = res[0];
  assign bus.vtx1_Y_raw = res[1];
  assign bus.vtx2_X_raw = res[2];
  assign bus.vtx2_Y_raw = res[3];
  assign bus.vtx3_X_raw = res[4];
  assign bus.vtx3_Y_raw = res[5];
  assign bus.vtx4_X_raw = res[6];
  assign bus.vtx4_Y_raw = res[7];
  assign bus.vtx1_Z_raw = z_res[0];
  assign bus.vtx2_Z_raw = z_res[1];
  assign bus.vtx3_Z_raw = z_res[2];
  assign bus.vtx4_Z_raw = z_res[3];
endmodule

// File: tb/tb_screen_unscaling.sv
// Directed and randomized checks of the screen-space unscaling stage.
module tb_screen_unscaling;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  screen_unscaling_if bus();
  screen_unscaling dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  logic signed [20:0] sx [4], sy [4], sz [4];
  logic signed [20:0] rx [4], ry [4], rz [4];
  logic signed [20:0] ex [4], ey [4], ez [4];

  function automatic logic signed [20:0] c(input int v);
    return v[20:0];
  endfunction

  function automatic longint model_q(input logic signed [20:0] s, input bit is_y);
    longint num;
    num = longint'(s) * 64'sd1048576;
    return num / (is_y ? 64'sd7680 : 64'sd10240);
  endfunction

  function automatic logic signed [20:0] model(input logic signed [20:0] s, input bit is_y);
    longint q;
    q = model_q(s, is_y);
    if (q > 1048575)  q = 1048575;
    if (q < -1048576) q = -1048576;
    return q[20:0];
  endfunction

  task automatic apply();
    bus.vtx1_X_scaled = sx[0]; bus.vtx1_Y_scaled = sy[0]; bus.vtx1_Z_scaled = sz[0];
    bus.vtx2_X_scaled = sx[1]; bus.vtx2_Y_scaled = sy[1]; bus.vtx2_Z_scaled = sz[1];
    bus.vtx3_X_scaled = sx[2]; bus.vtx3_Y_scaled = sy[2]; bus.vtx3_Z_scaled = sz[2];
    bus.vtx4_X_scaled = sx[3]; bus.vtx4_Y_scaled = sy[3]; bus.vtx4_Z_scaled = sz[3];
  endtask

  task automatic read_out();
    rx[0] = bus.vtx1_X_raw; ry[0] = bus.vtx1_Y_raw; rz[0] = bus.vtx1_Z_raw;
    rx[1] = bus.vtx2_X_raw; ry[1] = bus.vtx2_Y_raw; rz[1] = bus.vtx2_Z_raw;
    rx[2] = bus.vtx3_X_raw; ry[2] = bus.vtx3_Y_raw; rz[2] = bus.vtx3_Z_raw;
    rx[3] = bus.vtx4_X_raw; ry[3] = bus.vtx4_Y_raw; rz[3] = bus.vtx4_Z_raw;
  endtask

  // Accept one packet at the next edge and wait (bounded) for out_valid; lat counts edges after acceptance.
  task automatic send_and_wait(output int lat);
    apply();
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    read_out();
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin sx[i] = '0; sy[i] = '0; sz[i] = '0; end
    apply();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    read_out();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx[i] !== 0 || ry[i] !== 0 || rz[i] !== 0) begin
        bad++; $display("FAIL reset_out v%0d got=%0d,%0d,%0d exp=0,0,0", i+1, rx[i], ry[i], rz[i]);
      end
    end
  endtask

  task automatic test_unit();
    int lat;
    for (int i = 0; i < 4; i++) begin
      sx[i] = c(320); sy[i] = c(240); sz[i] = c(7);
      ex[i] = c(32768); ey[i] = c(32768); ez[i] = c(7);
    end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL unit_idle_ready got=%0b exp=1", bus.in_ready); end
    send_and_wait(lat);
    total++; if (lat !== 264) begin bad++; $display("FAIL unit_latency got=%0d exp=264", lat); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL unit_done_ready got=%0b exp=0", bus.in_ready); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx[i] !== ex[i] || ry[i] !== ey[i] || rz[i] !== ez[i]) begin
        bad++; $display("FAIL unit_out v%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", i+1, rx[i], ry[i], rz[i], ex[i], ey[i], ez[i]);
      end
    end
    release_out();
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL unit_release got ready=%0b valid=%0b exp ready=1 valid=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_signs();
    int lat;
    sx[0] = c(-160); sy[0] = c(-120); sz[0] = c(0);
    sx[1] = c(1);    sy[1] = c(1);    sz[1] = c(-5);
    sx[2] = c(-1);   sy[2] = c(0);    sz[2] = c(100);
    sx[3] = c(0);    sy[3] = c(-1);   sz[3] = c(-1048576);
    ex[0] = c(-16384); ey[0] = c(-16384); ex[1] = c(102); ey[1] = c(136);
    ex[2] = c(-102);   ey[2] = c(0);      ex[3] = c(0);   ey[3] = c(-136);
    for (int i = 0; i < 4; i++) ez[i] = sz[i];
    send_and_wait(lat);
    total++; if (lat !== 264) begin bad++; $display("FAIL signs_latency got=%0d exp=264", lat); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx[i] !== ex[i] || ry[i] !== ey[i] || rz[i] !== ez[i]) begin
        bad++; $display("FAIL signs_out v%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", i+1, rx[i], ry[i], rz[i], ex[i], ey[i], ez[i]);
      end
    end
    release_out();
  endtask

  task automatic test_saturation();
    int lat;
    sx[0] = c(1048575); sy[0] = c(-1048576); sz[0] = c(1048575);
    sx[1] = c(2048);    sy[1] = c(-2048);    sz[1] = c(12345);
    sx[2] = c(-10240);  sy[2] = c(7680);     sz[2] = c(-2);
    sx[3] = c(10239);   sy[3] = c(-7679);    sz[3] = c(3);
    ex[0] = c(1048575);  ey[0] = c(-1048576);
    ex[1] = c(209715);   ey[1] = c(-279620);
    ex[2] = c(-1048576); ey[2] = c(1048575);
    ex[3] = c(1048473);  ey[3] = c(-1048439);
    for (int i = 0; i < 4; i++) ez[i] = sz[i];
    send_and_wait(lat);
    total++; if (lat !== 264) begin bad++; $display("FAIL sat_latency got=%0d exp=264", lat); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx[i] !== ex[i] || ry[i] !== ey[i] || rz[i] !== ez[i]) begin
        bad++; $display("FAIL sat_out v%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", i+1, rx[i], ry[i], rz[i], ex[i], ey[i], ez[i]);
      end
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    for (int i = 0; i < 4; i++) begin
      sx[i] = c(5); sy[i] = c(15); sz[i] = c(i + 1);
      ex[i] = c(512); ey[i] = c(2048); ez[i] = c(i + 1);
    end
    send_and_wait(lat);
    total++; if (lat !== 264) begin bad++; $display("FAIL bp_latency got=%0d exp=264", lat); end
    for (int i = 0; i < 4; i++) begin sx[i] = c(-999); sy[i] = c(777); sz[i] = c(50 + i); end
    apply();
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      read_out();
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_hs cyc=%0d got valid=%0b ready=%0b exp valid=1 ready=0", cyc, bus.out_valid, bus.in_ready);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (rx[i] !== ex[i] || ry[i] !== ey[i] || rz[i] !== ez[i]) begin
          bad++; $display("FAIL bp_hold_out cyc=%0d v%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", cyc, i+1, rx[i], ry[i], rz[i], ex[i], ey[i], ez[i]);
        end
      end
    end
    bus.in_valid = 1'b0;
    release_out();
    read_out();
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got ready=%0b valid=%0b exp ready=1 valid=0", bus.in_ready, bus.out_valid);
    end
    total++; if (rz[0] !== ez[0] || rx[0] !== ex[0]) begin
      bad++; $display("FAIL bp_no_resample got x=%0d z=%0d exp x=%0d z=%0d", rx[0], rz[0], ex[0], ez[0]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin sx[i] = c(320); sy[i] = c(240); sz[i] = c(9); end
    apply();
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    read_out();
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_hs got valid=%0b ready=%0b exp valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx[i] !== 0 || ry[i] !== 0 || rz[i] !== 0) begin
        bad++; $display("FAIL midrst_out v%0d got=%0d,%0d,%0d exp=0,0,0", i+1, rx[i], ry[i], rz[i]);
      end
    end
    test_signs();
  endtask

  function automatic logic signed [20:0] rnd_coord();
    int v;
    case ($urandom_range(0, 9))
      0:       v = -1048576;
      1:       v = 1048575;
      2, 3, 4, 5: v = int'($urandom_range(0, 24000)) - 12000;
      default: v = int'($urandom_range(0, 2097151)) - 1048576;
    endcase
    return c(v);
  endfunction

  task automatic test_random(input int n);
    int lat, k;
    longint q, fwd;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < 4; i++) begin
        sx[i] = rnd_coord(); sy[i] = rnd_coord(); sz[i] = rnd_coord();
        ex[i] = model(sx[i], 1'b0); ey[i] = model(sy[i], 1'b1); ez[i] = sz[i];
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      send_and_wait(lat);
      bus.out_ready = 1'b0;
      total++; if (lat !== 264) begin bad++; $display("FAIL rnd_latency pkt=%0d got=%0d exp=264", p, lat); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (rx[i] !== ex[i] || ry[i] !== ey[i] || rz[i] !== ez[i]) begin
          bad++; $display("FAIL rnd_out pkt=%0d v%0d in=%0d,%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d",
                          p, i+1, sx[i], sy[i], rx[i], ry[i], rz[i], ex[i], ey[i], ez[i]);
        end
        q = model_q(sx[i], 1'b0);
        if (q <= 1048575 && q >= -1048576) begin
          fwd = (longint'(rx[i]) * 64'sd10240) >>> 20;
          total++;
          if (fwd - longint'(sx[i]) > 1 || longint'(sx[i]) - fwd > 1) begin
            bad++; $display("FAIL rnd_roundtrip_x pkt=%0d v%0d got=%0d exp=%0d+-1", p, i+1, fwd, sx[i]);
          end
        end
        q = model_q(sy[i], 1'b1);
        if (q <= 1048575 && q >= -1048576) begin
          fwd = (longint'(ry[i]) * 64'sd7680) >>> 20;
          total++;
          if (fwd - longint'(sy[i]) > 1 || longint'(sy[i]) - fwd > 1) begin
            bad++; $display("FAIL rnd_roundtrip_y pkt=%0d v%0d got=%0d exp=%0d+-1", p, i+1, fwd, sy[i]);
          end
        end
      end
      k = int'($urandom_range(0, 3));
      for (int h = 0; h < k; h++) begin
        @(posedge clk); #1;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rnd_hold pkt=%0d got=%0b exp=1", p, bus.out_valid); end
      end
      release_out();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_unit();
    test_signs();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random(150);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
